// File: rtl/ext_code_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ext_code_pkg
//  Brief    : Shared widths and FSM state encoding for the external code loader.
//  Revision : 1.0
// ============================================================================
package ext_code_pkg;

    localparam int SLOT_W  = 3;
    localparam int CODE_W  = 32;
    localparam int INDEX_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_W_IDX      = 4'd1,
        ST_W_IDX_GAP  = 4'd2,
        ST_W_CODE     = 4'd3,
        ST_W_CODE_GAP = 4'd4,
        ST_R_IDX      = 4'd5,
        ST_R_IDX_GAP  = 4'd6,
        ST_R_HIGH     = 4'd7,
        ST_R_LOW      = 4'd8,
        ST_DONE       = 4'd9
    } state_t;

endpackage : ext_code_pkg
`default_nettype wire

// File: rtl/ext_code_strobe.sv
`default_nettype none
// ============================================================================
//  Module   : ext_code_strobe
//  Brief    : Loadable down-counter timing one high phase followed by a gap.
//  Revision : 1.0
// ============================================================================
module ext_code_strobe
    import ext_code_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_highLen,
    input  logic [CNT_W-1:0] i_gapLen,
    output logic             o_highLast,
    output logic             o_gapLast
);

    logic             r_active;
    logic             r_gapPhase;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_gapLen;

    // Lengths are at least 1; the counter holds (remaining cycles - 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active   <= 1'b0;
            r_gapPhase <= 1'b0;
            r_cnt      <= '0;
            r_gapLen   <= '0;
        end else if (i_load) begin
            r_active   <= 1'b1;
            r_gapPhase <= 1'b0;
            r_cnt      <= i_highLen - CNT_W'(1);
            r_gapLen   <= i_gapLen;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                if (!r_gapPhase) begin
                    r_gapPhase <= 1'b1;
                    r_cnt      <= r_gapLen - CNT_W'(1);
                end else begin
                    r_active <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_highLast = r_active & ~r_gapPhase & (r_cnt == '0);
    assign o_gapLast  = r_active &  r_gapPhase & (r_cnt == '0);

endmodule : ext_code_strobe
`default_nettype wire

// File: rtl/ext_code_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ext_code_loader
//  Brief    : Host writer and playback sequencer for the 8-slot code table.
//             EXT_CODE_LOOP_EN makes playback repeat until iStop.
//  Revision : 1.0
// ============================================================================
module ext_code_loader
    import ext_code_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2,
    parameter int DWELL_W = 16
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iWr_valid,
    output logic               oWr_ready,
    input  logic [SLOT_W-1:0]  iWr_slot,
    input  logic [CODE_W-1:0]  iWr_code,
    input  logic               iStart,
    input  logic               iStop,
    input  logic [3:0]         iStep_count,
    input  logic [DWELL_W-1:0] iDwell,
    output logic               oSET_INDEX_FLAG,
    output logic [INDEX_W-1:0] oSET_INDEX,
    output logic               oSET_CODE_FLAG,
    output logic [CODE_W-1:0]  oSET_CODE,
    output logic               oTrigger,
    output logic               oBusy,
    output logic               oDone
);

    localparam logic [DWELL_W-1:0] c_PULSE_LEN = DWELL_W'(PULSE_W);
    localparam logic [DWELL_W-1:0] c_GAP_LEN   = DWELL_W'(GAP_W);

    state_t               r_state;
    state_t               w_nextState;
    logic [3:0]           r_count;
    logic [3:0]           r_stepCnt;
    logic [DWELL_W-1:0]   r_dwell;
    logic                 r_stopPend;

    logic                 w_load;
    logic [DWELL_W-1:0]   w_highLen;
    logic [DWELL_W-1:0]   w_gapLen;
    logic                 w_highLast;
    logic                 w_gapLast;
    logic                 w_accept;
    logic                 w_startRun;
    logic                 w_stepInc;
    logic                 w_stepClr;
    logic                 w_inRun;
    logic                 w_stopNow;
    logic [3:0]           w_stepNext;
    logic [DWELL_W-1:0]   w_dwellEff;

    assign w_stepNext = r_stepCnt + 4'd1;
    assign w_dwellEff = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
    assign w_inRun    = (r_state == ST_R_IDX) || (r_state == ST_R_IDX_GAP) ||
                        (r_state == ST_R_HIGH) || (r_state == ST_R_LOW);
    assign w_stopNow  = r_stopPend | iStop;

    ext_code_strobe #(
        .CNT_W (DWELL_W)
    ) u_strobe (
        .clk        (iClk),
        .rst        (iRst),
        .i_load     (w_load),
        .i_highLen  (w_highLen),
        .i_gapLen   (w_gapLen),
        .o_highLast (w_highLast),
        .o_gapLast  (w_gapLast)
    );

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_highLen   = c_PULSE_LEN;
        w_gapLen    = c_GAP_LEN;
        w_accept    = 1'b0;
        w_startRun  = 1'b0;
        w_stepInc   = 1'b0;
        w_stepClr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A write and a start in the same cycle: the write wins.
                if (iWr_valid && oWr_ready) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_nextState = ST_W_IDX;
                end else if (iStart) begin
                    w_startRun  = 1'b1;
                    w_load      = 1'b1;
                    w_nextState = ST_R_IDX;
                end
            end
            ST_W_IDX:      if (w_highLast) w_nextState = ST_W_IDX_GAP;
            ST_W_IDX_GAP: begin
                if (w_gapLast) begin
                    w_load      = 1'b1;
                    w_nextState = ST_W_CODE;
                end
            end
            ST_W_CODE:     if (w_highLast) w_nextState = ST_W_CODE_GAP;
            ST_W_CODE_GAP: if (w_gapLast)  w_nextState = ST_IDLE;
            ST_R_IDX:      if (w_highLast) w_nextState = ST_R_IDX_GAP;
            ST_R_IDX_GAP: begin
                if (w_gapLast) begin
                    if ((r_count == 4'd0) || w_stopNow) begin
                        w_nextState = ST_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_highLen   = w_dwellEff;
                        w_nextState = ST_R_HIGH;
                    end
                end
            end
            ST_R_HIGH:     if (w_highLast) w_nextState = ST_R_LOW;
            ST_R_LOW: begin
                if (w_gapLast) begin
                    w_stepInc = 1'b1;
                    if (w_stopNow) begin
                        w_nextState = ST_DONE;
                    end else if (w_stepNext == r_count) begin
`ifdef EXT_CODE_LOOP_EN
                        // The table wraps its own index, so no index reset here.
                        w_stepClr   = 1'b1;
                        w_load      = 1'b1;
                        w_highLen   = w_dwellEff;
                        w_nextState = ST_R_HIGH;
`else
                        w_nextState = ST_DONE;
`endif
                    end else begin
                        w_load      = 1'b1;
                        w_highLen   = w_dwellEff;
                        w_nextState = ST_R_HIGH;
                    end
                end
            end
            ST_DONE:       w_nextState = ST_IDLE;
            default:       w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state         <= ST_IDLE;
            r_count         <= 4'd0;
            r_stepCnt       <= 4'd0;
            r_dwell         <= '0;
            r_stopPend      <= 1'b0;
            oWr_ready       <= 1'b0;
            oBusy           <= 1'b0;
            oDone           <= 1'b0;
            oSET_INDEX_FLAG <= 1'b0;
            oSET_CODE_FLAG  <= 1'b0;
            oTrigger        <= 1'b0;
            oSET_INDEX      <= '0;
            oSET_CODE       <= '0;
        end else begin
            r_state         <= w_nextState;
            // Outputs decode the next state so they align with the state register.
            oWr_ready       <= (w_nextState == ST_IDLE);
            oBusy           <= (w_nextState != ST_IDLE);
            oDone           <= (w_nextState == ST_DONE);
            oSET_INDEX_FLAG <= (w_nextState == ST_W_IDX) || (w_nextState == ST_R_IDX);
            oSET_CODE_FLAG  <= (w_nextState == ST_W_CODE);
            oTrigger        <= (w_nextState == ST_R_HIGH);
            r_stopPend      <= w_inRun & w_stopNow;

            if (w_accept) begin
                oSET_INDEX <= INDEX_W'(iWr_slot);
                oSET_CODE  <= iWr_code;
            end else if (w_startRun) begin
                oSET_INDEX <= '0;
            end

            if (w_startRun) begin
                r_count   <= iStep_count;
                r_dwell   <= iDwell;
                r_stepCnt <= 4'd0;
            end else if (w_stepClr) begin
                r_stepCnt <= 4'd0;
            end else if (w_stepInc) begin
                r_stepCnt <= w_stepNext;
            end
        end
    end

endmodule : ext_code_loader
`default_nettype wire

// File: tb/tb_ext_code_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ext_code_loader
//  Brief    : Randomized self-checking bench; expectations come from cycle
//             formulas of the loader timing (EXT_CODE_LOOP_EN aware).
//  Revision : 1.0
// ============================================================================
module tb_ext_code_loader;

    localparam int P = 2;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        iRst;
    logic        iWr_valid;
    logic        oWr_ready;
    logic [2:0]  iWr_slot;
    logic [31:0] iWr_code;
    logic        iStart;
    logic        iStop;
    logic [3:0]  iStep_count;
    logic [15:0] iDwell;
    logic        oSET_INDEX_FLAG;
    logic [7:0]  oSET_INDEX;
    logic        oSET_CODE_FLAG;
    logic [31:0] oSET_CODE;
    logic        oTrigger;
    logic        oBusy;
    logic        oDone;

    int          nVectors     = 0;
    int          nMiscompares = 0;
    logic [7:0]  expIndex;
    logic [31:0] expCode;

    always #5 clk = ~clk;

    ext_code_loader #(
        .PULSE_W (P),
        .GAP_W   (G),
        .DWELL_W (16)
    ) dut (
        .iClk            (clk),
        .iRst            (iRst),
        .iWr_valid       (iWr_valid),
        .oWr_ready       (oWr_ready),
        .iWr_slot        (iWr_slot),
        .iWr_code        (iWr_code),
        .iStart          (iStart),
        .iStop           (iStop),
        .iStep_count     (iStep_count),
        .iDwell          (iDwell),
        .oSET_INDEX_FLAG (oSET_INDEX_FLAG),
        .oSET_INDEX      (oSET_INDEX),
        .oSET_CODE_FLAG  (oSET_CODE_FLAG),
        .oSET_CODE       (oSET_CODE),
        .oTrigger        (oTrigger),
        .oBusy           (oBusy),
        .oDone           (oDone)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    task automatic idleInputs();
        iWr_valid = 1'b0;
        iStart    = 1'b0;
        iStop     = 1'b0;
    endtask

    // Write accepted at cycle T; k counts cycles after T.
    task automatic doWrite(input logic [2:0] slot, input logic [31:0] code, input bit withStart);
        int L;
        L = 2 * (P + G);
        @(negedge clk);
        chk("wrReadyPre", 32'(oWr_ready), 32'd1);
        iWr_valid = 1'b1;
        iWr_slot  = slot;
        iWr_code  = code;
        iStart    = withStart;
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            idleInputs();
            chk("wrIdxFlag",  32'(oSET_INDEX_FLAG), 32'(k <= P));
            chk("wrCodeFlag", 32'(oSET_CODE_FLAG),  32'((k > P + G) && (k <= 2 * P + G)));
            chk("wrTrigger",  32'(oTrigger), 32'd0);
            chk("wrDone",     32'(oDone),    32'd0);
            chk("wrReady",    32'(oWr_ready), 32'(k == L + 1));
            chk("wrBusy",     32'(oBusy),     32'(k <= L));
            chk("wrIndex",    32'(oSET_INDEX), 32'({5'b0, slot}));
            chk("wrCode",     oSET_CODE, code);
            if (k <= L) begin
                // Commands while busy must be ignored.
                iWr_valid = 1'($urandom_range(0, 1));
                iWr_slot  = 3'($urandom);
                iWr_code  = $urandom;
                iStart    = 1'($urandom_range(0, 1));
                iStop     = 1'($urandom_range(0, 1));
            end
        end
        expIndex = {5'b0, slot};
        expCode  = code;
    endtask

    // Playback started at cycle S; stopStep is the 1-based step whose trigger sees iStop.
    task automatic doRun(input int count, input int dwell, input int stopStep);
        int d, base0, nSteps, doneC, stopC, off, stp;
        bit trigExp;
        d     = (dwell == 0) ? 1 : dwell;
        base0 = 1 + P + G;
        stp   = stopStep;
`ifdef EXT_CODE_LOOP_EN
        if (count == 0) begin
            nSteps = 0;
            stp    = 0;
        end else begin
            if (stp == 0) stp = count + 2;
            nSteps = stp;
        end
`else
        if (stp > 0 && stp <= count) begin
            nSteps = stp;
        end else begin
            nSteps = count;
            stp    = 0;
        end
`endif
        doneC = base0 + nSteps * (d + G);
        stopC = (stp > 0) ? base0 + (stp - 1) * (d + G) + $urandom_range(0, d - 1) : -1;
        @(negedge clk);
        chk("runReadyPre", 32'(oWr_ready), 32'd1);
        iStart      = 1'b1;
        iStep_count = 4'(count);
        iDwell      = 16'(dwell);
        for (int k = 1; k <= doneC + 1; k++) begin
            @(negedge clk);
            idleInputs();
            iStep_count = 4'($urandom);
            iDwell      = 16'($urandom);
            trigExp = 1'b0;
            if (k >= base0 && k < doneC) begin
                off     = (k - base0) % (d + G);
                trigExp = (off < d);
            end
            chk("runIdxFlag",  32'(oSET_INDEX_FLAG), 32'(k <= P));
            chk("runCodeFlag", 32'(oSET_CODE_FLAG), 32'd0);
            chk("runTrigger",  32'(oTrigger), 32'(trigExp));
            chk("runDone",     32'(oDone),   32'(k == doneC));
            chk("runBusy",     32'(oBusy),   32'(k <= doneC));
            chk("runReady",    32'(oWr_ready), 32'(k > doneC));
            chk("runIndex",    32'(oSET_INDEX), 32'd0);
            chk("runCode",     oSET_CODE, expCode);
            if (k == stopC) begin
                iStop = 1'b1;
            end else if (k <= doneC && $urandom_range(0, 3) == 0) begin
                iWr_valid = 1'b1;
                iWr_slot  = 3'($urandom);
                iWr_code  = $urandom;
                iStart    = 1'($urandom_range(0, 1));
            end
        end
        expIndex = 8'd0;
    endtask

    // Reset lands while the code strobe is high.
    task automatic doResetMidWrite(input logic [2:0] slot, input logic [31:0] code);
        @(negedge clk);
        chk("rstReadyPre", 32'(oWr_ready), 32'd1);
        iWr_valid = 1'b1;
        iWr_slot  = slot;
        iWr_code  = code;
        for (int k = 1; k <= P + G + 1; k++) begin
            @(negedge clk);
            idleInputs();
        end
        chk("rstInWCode", 32'(oSET_CODE_FLAG), 32'd1);
        iRst = 1'b1;
        @(negedge clk);
        iRst = 1'b0;
        chk("rstIdxFlag",  32'(oSET_INDEX_FLAG), 32'd0);
        chk("rstCodeFlag", 32'(oSET_CODE_FLAG), 32'd0);
        chk("rstTrigger",  32'(oTrigger), 32'd0);
        chk("rstBusy",     32'(oBusy), 32'd0);
        chk("rstDone",     32'(oDone), 32'd0);
        chk("rstReadyLow", 32'(oWr_ready), 32'd0);
        @(negedge clk);
        chk("rstReadyHigh", 32'(oWr_ready), 32'd1);
        chk("rstBusyAfter", 32'(oBusy), 32'd0);
        expIndex = 8'd0;
        expCode  = 32'd0;
    endtask

    initial begin
        iRst        = 1'b1;
        iWr_slot    = 3'd0;
        iWr_code    = 32'd0;
        iStep_count = 4'd0;
        iDwell      = 16'd0;
        idleInputs();
        expIndex = 8'd0;
        expCode  = 32'd0;
        repeat (3) @(negedge clk);
        chk("resetReady", 32'(oWr_ready), 32'd0);
        chk("resetBusy",  32'(oBusy), 32'd0);
        chk("resetFlags", 32'({oSET_INDEX_FLAG, oSET_CODE_FLAG, oTrigger, oDone}), 32'd0);
        chk("resetIndex", 32'(oSET_INDEX), 32'd0);
        chk("resetCode",  oSET_CODE, 32'd0);
        iRst = 1'b0;
        @(negedge clk);
        chk("releaseReady", 32'(oWr_ready), 32'd1);

        doWrite(3'd3, 32'hDEADBEEF, 1'b0);
        doRun(3, 5, 0);
        doRun(0, 5, 0);
        doRun(8, 5, 2);
        doResetMidWrite(3'd6, 32'h12345678);
        doWrite(3'd5, 32'hA5A5_0F0F, 1'b1);
        doRun(2, 3, 5);
        doRun(4, 0, 0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0, 1: doWrite(3'($urandom), $urandom, 1'($urandom_range(0, 1)));
                2, 3: doRun($urandom_range(0, 6), $urandom_range(0, 5),
                            ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0);
                default: doResetMidWrite(3'($urandom), $urandom);
            endcase
        end
        doRun(15, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule : tb_ext_code_loader
`default_nettype wire
